// File: rtl/seg_pkg.sv
// Glyph constants, digit decoder and converter state type shared by the
// seven-segment scan driver and its sequential binary-to-BCD converter.
package seg_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, handshake on the
// input side, and a commit pulse that hands the result to the display.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         num_valid,
  input  logic [BIN_W-1:0]             num,
  input  logic [DIGITS-1:0]            dot_mask,
  output logic                         num_ready,
  output logic                         commit,
  output logic [DIGITS-1:0][3:0]       bcd,
  output logic [DIGITS-1:0]            dots,
  output logic                         overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic               carry_q, carry_d;
  logic [DIGITS-1:0]  dots_q, dots_d;
  logic               ready_q, ready_d;
  logic               ovf_q, ovf_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    dots_d  = dots_q;
    ready_d = ready_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (num_valid && ready_q) begin
        bin_d   = num;
        dots_d  = dot_mask;
        bcd_d   = '0;
        carry_d = 1'b0;
        cnt_d   = '0;
        ready_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // A bit leaving the top nibble means the value needs more than DIGITS digits.
        bcd_d   = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        carry_d = carry_q | adj[BCD_W-1];
        bin_d   = bin_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        ovf_d   = carry_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      dots_q  <= '0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      dots_q  <= dots_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
    end
  end

  assign num_ready = ready_q;
  assign commit    = (state_q == COMMIT);
  assign bcd       = bcd_q;
  assign dots      = dots_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: holds the committed BCD value and scans
// it onto a shared segment bus with leading-zero blanking and overflow dashes.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 16,
  parameter int REFRESH_DIV = 1000,
  parameter int ANODE_ACT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              num_valid,
  input  logic [BIN_W-1:0]  num,
  input  logic [DIGITS-1:0] dot_mask,
  input  logic              blank_lz,
  output logic              num_ready,
  output logic [7:0]        segments,
  output logic [DIGITS-1:0] anodes,
  output logic              overflow
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [DIGITS-1:0] AN_OFF = (ANODE_ACT != 0) ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

  logic                   conv_commit;
  logic [DIGITS-1:0][3:0] conv_bcd;
  logic [DIGITS-1:0]      conv_dots;

  bin2bcd_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .num_valid (num_valid),
    .num       (num),
    .dot_mask  (dot_mask),
    .num_ready (num_ready),
    .commit    (conv_commit),
    .bcd       (conv_bcd),
    .dots      (conv_dots),
    .overflow  (overflow)
  );

  logic [DIGITS-1:0][3:0] disp_bcd_q, disp_bcd_d;
  logic [DIGITS-1:0]      disp_dots_q, disp_dots_d;
  logic [PRE_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      an_q, an_d, onehot;
  logic [DIGITS-1:0]      lz_mask;
  logic                   zero_run, blank;
  logic [6:0]             glyph;

  always_comb begin
    disp_bcd_d  = conv_commit ? conv_bcd  : disp_bcd_q;
    disp_dots_d = conv_commit ? conv_dots : disp_dots_q;

    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // lz_mask[i]: digit i and every digit above it are zero.
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (disp_bcd_q[i] == 4'd0);
      lz_mask[i] = zero_run;
    end

    blank = blank_lz && !overflow && (idx_q != '0) && lz_mask[idx_q];
    if (overflow)   glyph = SEG_DASH;
    else if (blank) glyph = SEG_BLANK;
    else            glyph = seg_decode(disp_bcd_q[idx_q]);

    seg_d  = {disp_dots_q[idx_q], glyph};
    onehot = DIGITS'(1) << idx_q;
    an_d   = (ANODE_ACT != 0) ? onehot : ~onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bcd_q  <= '0;
      disp_dots_q <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      seg_q       <= '0;
      an_q        <= AN_OFF;
    end else begin
      disp_bcd_q  <= disp_bcd_d;
      disp_dots_q <= disp_dots_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign segments = seg_q;
  assign anodes   = an_q;

endmodule
